// File: rtl/bcd_pkg.sv
// Shared types and constants for the arbitrated binary-to-BCD engine.
// Used by the sequencer and the combinational dabble step.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int         BCD_W       = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] SAT_DIGIT   = 4'd9;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: conditional add-3 on each digit,
// then shift the three digits left with a new bit entering the ones.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_hund,
  input  logic [BCD_W-1:0] i_ten,
  input  logic [BCD_W-1:0] i_one,
  input  logic             i_bit,
  output logic [BCD_W-1:0] o_hund,
  output logic [BCD_W-1:0] o_ten,
  output logic [BCD_W-1:0] o_one
);

  logic [BCD_W-1:0] w_h;
  logic [BCD_W-1:0] w_t;
  logic [BCD_W-1:0] w_o;

  function automatic logic [BCD_W-1:0] adj(
    input logic [BCD_W-1:0] d
  );
    return (d >= ADD3_THRESH) ? d + 4'd3 : d;
  endfunction

  assign w_h = adj(i_hund);
  assign w_t = adj(i_ten);
  assign w_o = adj(i_one);

  assign o_hund = {w_h[BCD_W-2:0], w_t[BCD_W-1]};
  assign o_ten  = {w_t[BCD_W-2:0], w_o[BCD_W-1]};
  assign o_one  = {w_o[BCD_W-2:0], i_bit};

endmodule

// File: rtl/bcd_conv_arb.sv
// Two-client round-robin binary-to-BCD converter, one bit per clock.
// Digit outputs only change on DONE, so they are never seen partial.
module bcd_conv_arb
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int MAXVAL = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] bin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] bin1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             done,
  output logic             src,
  output logic [BCD_W-1:0] hund,
  output logic [BCD_W-1:0] ten,
  output logic [BCD_W-1:0] one,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_sh;
  logic [BCD_W-1:0] r_dh;
  logic [BCD_W-1:0] r_dt;
  logic [BCD_W-1:0] r_do;
  logic [CW-1:0]    r_cnt;
  logic             r_sel;
  logic             r_ptr;
  logic             r_ovf_p;

  logic [BCD_W-1:0] r_hund;
  logic [BCD_W-1:0] r_ten;
  logic [BCD_W-1:0] r_one;
  logic             r_ovf;
  logic             r_src;
  logic             r_done;
  logic             r_ack0;
  logic             r_ack1;

  logic             w_req_any;
  logic             w_idx;
  logic [WIDTH-1:0] w_op;
  logic             w_ovf;
  logic [BCD_W-1:0] w_nh;
  logic [BCD_W-1:0] w_nt;
  logic [BCD_W-1:0] w_no;

  // Pointer only matters when both clients ask at once.
  assign w_req_any = req0 | req1;
  assign w_idx     = (req0 & req1) ? r_ptr : req1;
  assign w_op      = w_idx ? bin1 : bin0;
  assign w_ovf     = int'(w_op) > MAXVAL;

  bcd_dabble_step u_step (
    .i_hund (r_dh),
    .i_ten  (r_dt),
    .i_one  (r_do),
    .i_bit  (r_sh[WIDTH-1]),
    .o_hund (w_nh),
    .o_ten  (w_nt),
    .o_one  (w_no)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req_any) w_next = SHIFT;
      SHIFT:   if (r_cnt == CW'(WIDTH - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh    <= '0;
      r_dh    <= '0;
      r_dt    <= '0;
      r_do    <= '0;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_ptr   <= 1'b0;
      r_ovf_p <= 1'b0;
      r_hund  <= '0;
      r_ten   <= '0;
      r_one   <= '0;
      r_ovf   <= 1'b0;
      r_src   <= 1'b0;
      r_done  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_sh    <= w_op;
            r_dh    <= '0;
            r_dt    <= '0;
            r_do    <= '0;
            r_sel   <= w_idx;
            r_ovf_p <= w_ovf;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
          r_dh  <= w_nh;
          r_dt  <= w_nt;
          r_do  <= w_no;
          r_cnt <= r_cnt + CW'(1);
        end
        DONE: begin
          r_hund <= r_ovf_p ? SAT_DIGIT : r_dh;
          r_ten  <= r_ovf_p ? SAT_DIGIT : r_dt;
          r_one  <= r_ovf_p ? SAT_DIGIT : r_do;
          r_ovf  <= r_ovf_p;
          r_src  <= r_sel;
          r_done <= 1'b1;
          r_ack0 <= ~r_sel;
          r_ack1 <= r_sel;
          r_ptr  <= ~r_sel;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign ack0 = r_ack0;
  assign ack1 = r_ack1;
  assign src  = r_src;
  assign hund = r_hund;
  assign ten  = r_ten;
  assign one  = r_one;
  assign ovf  = r_ovf;

endmodule
